pwm_cfg_scheduler: RTL and testbench

//  Sits between spi_peripheral and pwm_peripheral.
//  - Owns the five PWM configuration registers and decodes SPI register writes.
//  - Holds writes in shadow registers; commits them to the PWM either immediately or at the next PWM period start.
//  - Second requester: an internal duty-ramp engine that steps pwm_duty_cycle toward a target, one step per N periods.
//  - Arbitrates SPI and ramp access to the duty register.

---
 rtl/pwm_cfg_pkg.sv | 25 ++
 rtl/pwm_ramp_stepper.sv | 61 ++++++
 rtl/pwm_cfg_scheduler.sv | 138 +++++++++++++
 tb/tb_pwm_cfg_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cfg_pkg.sv
// Shared constants and types for the PWM configuration scheduler.
package pwm_cfg_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned ADDR_W_DEFAULT = 7;
    localparam int unsigned DIV_W_DEFAULT  = 4;

    // Register map; everything from 0x08 upward is unmapped.
    localparam logic [6:0] REG_EN_OUT_LO   = 7'h00;
    localparam logic [6:0] REG_EN_OUT_HI   = 7'h01;
    localparam logic [6:0] REG_EN_PWM_LO   = 7'h02;
    localparam logic [6:0] REG_EN_PWM_HI   = 7'h03;
    localparam logic [6:0] REG_DUTY        = 7'h04;
    localparam logic [6:0] REG_RAMP_TARGET = 7'h05;
    localparam logic [6:0] REG_RAMP_STEP   = 7'h06;
    localparam logic [6:0] REG_RAMP_CTRL   = 7'h07;
    localparam logic [6:0] REG_FIRST_UNMAP = 7'h08;

    typedef enum logic [1:0] {
        StIdle,
        StPending,
        StCommit
    } cfg_state_e;

endpackage

// File: rtl/pwm_ramp_stepper.sv
// Duty-ramp engine: counts period_start pulses and, every (div + 1)-th pulse,
// proposes a duty value one step closer to the target, clamped at the target.
module pwm_ramp_stepper
    import pwm_cfg_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DIV_W  = DIV_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              period_start_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] cur_duty_i,
    input  logic [DATA_W-1:0] target_i,
    input  logic [DATA_W-1:0] step_i,
    input  logic [DIV_W-1:0]  div_i,
    output logic              step_valid_o,
    output logic [DATA_W-1:0] next_duty_o,
    output logic              done_o
);

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DATA_W-1:0] step_eff;
    logic [DATA_W:0]   sum, diff;
    logic              pulse;

    // Direction compare, saturating step and divider next-state.
    always_comb begin
        step_eff     = (step_i == '0) ? DATA_W'(1) : step_i;
        sum          = {1'b0, cur_duty_i} + {1'b0, step_eff};
        diff         = {1'b0, cur_duty_i} - {1'b0, step_eff};
        done_o       = enable_i && (cur_duty_i == target_i);
        pulse        = enable_i && period_start_i && !done_o;
        step_valid_o = pulse && (div_cnt_q == div_i);

        if (cur_duty_i < target_i) begin
            next_duty_o = (sum >= {1'b0, target_i}) ? target_i : sum[DATA_W-1:0];
        end else begin
            // diff[DATA_W] set means the subtraction went below zero.
            next_duty_o = (diff[DATA_W] || (diff[DATA_W-1:0] <= target_i)) ?
                          target_i : diff[DATA_W-1:0];
        end

        div_cnt_d = div_cnt_q;
        if (!enable_i) begin
            div_cnt_d = '0;
        end else if (pulse) begin
            div_cnt_d = (div_cnt_q == div_i) ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    // Period divider state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// PWM configuration scheduler: decodes SPI writes into shadow registers,
// commits them to the active bank immediately or at period start, and
// arbitrates duty between SPI and the ramp engine.
module pwm_cfg_scheduler
    import pwm_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DIV_W  = DIV_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              period_start_i,
    input  logic              sync_mode_i,
    output logic [DATA_W-1:0] en_reg_out_7_0_o,
    output logic [DATA_W-1:0] en_reg_out_15_8_o,
    output logic [DATA_W-1:0] en_reg_pwm_7_0_o,
    output logic [DATA_W-1:0] en_reg_pwm_15_8_o,
    output logic [DATA_W-1:0] pwm_duty_cycle_o,
    output logic              commit_pending_o,
    output logic              ramp_busy_o,
    output logic              wr_err_o
);

    logic [3:0][DATA_W-1:0] shadow_en_q, shadow_en_d, active_en_q, active_en_d;
    logic [DATA_W-1:0]      shadow_duty_q, shadow_duty_d, active_duty_q, active_duty_d;
    logic [DATA_W-1:0]      ramp_target_q, ramp_target_d, ramp_step_q, ramp_step_d;
    logic [DIV_W-1:0]       ramp_div_q, ramp_div_d;
    logic                   ramp_en_q, ramp_en_d;
    logic                   wr_err_q, wr_err_d;
    cfg_state_e             state_q, state_d;

    logic              mapped, shadow_wr, duty_wr, step_apply, commit_now;
    logic              step_valid, ramp_done;
    logic [DATA_W-1:0] ramp_next;

    pwm_ramp_stepper #(
        .DATA_W(DATA_W),
        .DIV_W (DIV_W)
    ) u_stepper (
        .clk           (clk),
        .rst_n         (rst_n),
        .period_start_i(period_start_i),
        .enable_i      (ramp_en_q),
        .cur_duty_i    (active_duty_q),
        .target_i      (ramp_target_q),
        .step_i        (ramp_step_q),
        .div_i         (ramp_div_q),
        .step_valid_o  (step_valid),
        .next_duty_o   (ramp_next),
        .done_o        (ramp_done)
    );

    // Decode, shadow/active banks, ramp registers, arbitration and FSM next-state.
    always_comb begin
        mapped     = wr_addr_i < ADDR_W'(REG_FIRST_UNMAP);
        shadow_wr  = wr_valid_i && (wr_addr_i <= ADDR_W'(REG_DUTY));
        duty_wr    = wr_valid_i && (wr_addr_i == ADDR_W'(REG_DUTY));
        // SPI duty writes win over a same-cycle ramp step.
        step_apply = step_valid && !duty_wr;
        commit_now = !sync_mode_i || ((state_q == StPending) && period_start_i);

        shadow_en_d = shadow_en_q;
        if (shadow_wr && !duty_wr) begin
            shadow_en_d[wr_addr_i[1:0]] = wr_data_i;
        end
        shadow_duty_d = duty_wr ? wr_data_i : (step_apply ? ramp_next : shadow_duty_q);

        // Using the _d shadow folds a same-cycle write into the commit.
        active_en_d   = commit_now ? shadow_en_d : active_en_q;
        active_duty_d = (commit_now || step_apply) ? shadow_duty_d : active_duty_q;

        ramp_target_d = ramp_target_q;
        ramp_step_d   = ramp_step_q;
        ramp_div_d    = ramp_div_q;
        ramp_en_d     = ramp_en_q && !ramp_done;
        if (wr_valid_i && (wr_addr_i == ADDR_W'(REG_RAMP_TARGET))) ramp_target_d = wr_data_i;
        if (wr_valid_i && (wr_addr_i == ADDR_W'(REG_RAMP_STEP)))   ramp_step_d   = wr_data_i;
        if (wr_valid_i && (wr_addr_i == ADDR_W'(REG_RAMP_CTRL))) begin
            ramp_en_d  = wr_data_i[0];
            ramp_div_d = wr_data_i[DIV_W:1];
        end
        if (duty_wr) ramp_en_d = 1'b0;

        wr_err_d = wr_valid_i && !mapped;

        state_d = state_q;
        if (!sync_mode_i) begin
            state_d = StIdle;
        end else if ((state_q == StPending) && period_start_i) begin
            state_d = StCommit;
        end else if (shadow_wr) begin
            state_d = StPending;
        end else if (state_q == StCommit) begin
            state_d = StIdle;
        end
    end

    // All configuration state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_en_q   <= '0;
            active_en_q   <= '0;
            shadow_duty_q <= '0;
            active_duty_q <= '0;
            ramp_target_q <= '0;
            ramp_step_q   <= '0;
            ramp_div_q    <= '0;
            ramp_en_q     <= 1'b0;
            wr_err_q      <= 1'b0;
            state_q       <= StIdle;
        end else begin
            shadow_en_q   <= shadow_en_d;
            active_en_q   <= active_en_d;
            shadow_duty_q <= shadow_duty_d;
            active_duty_q <= active_duty_d;
            ramp_target_q <= ramp_target_d;
            ramp_step_q   <= ramp_step_d;
            ramp_div_q    <= ramp_div_d;
            ramp_en_q     <= ramp_en_d;
            wr_err_q      <= wr_err_d;
            state_q       <= state_d;
        end
    end

    assign en_reg_out_7_0_o  = active_en_q[0];
    assign en_reg_out_15_8_o = active_en_q[1];
    assign en_reg_pwm_7_0_o  = active_en_q[2];
    assign en_reg_pwm_15_8_o = active_en_q[3];
    assign pwm_duty_cycle_o  = active_duty_q;
    assign commit_pending_o  = (state_q == StPending);
    assign ramp_busy_o       = ramp_en_q;
    assign wr_err_o          = wr_err_q;

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Scoreboard bench for pwm_cfg_scheduler: stimulus pushes timed expectations,
// a negedge monitor pops and compares them.
module tb_pwm_cfg_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       period_start = 1'b0;
    logic       sync_mode = 1'b0;
    logic [7:0] en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
    logic       commit_pending, ramp_busy, wr_err;

    always #5 clk = ~clk;

    pwm_cfg_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_valid_i       (wr_valid),
        .wr_addr_i        (wr_addr),
        .wr_data_i        (wr_data),
        .period_start_i   (period_start),
        .sync_mode_i      (sync_mode),
        .en_reg_out_7_0_o (en_out_lo),
        .en_reg_out_15_8_o(en_out_hi),
        .en_reg_pwm_7_0_o (en_pwm_lo),
        .en_reg_pwm_15_8_o(en_pwm_hi),
        .pwm_duty_cycle_o (duty),
        .commit_pending_o (commit_pending),
        .ramp_busy_o      (ramp_busy),
        .wr_err_o         (wr_err)
    );

    localparam int S_EN0 = 0, S_EN1 = 1, S_EN2 = 2, S_EN3 = 3, S_DUTY = 4;
    localparam int S_PEND = 5, S_BUSY = 6, S_ERR = 7;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sig_val(int s);
        case (s)
            S_EN0:   return en_out_lo;
            S_EN1:   return en_out_hi;
            S_EN2:   return en_pwm_lo;
            S_EN3:   return en_pwm_hi;
            S_DUTY:  return duty;
            S_PEND:  return {7'b0, commit_pending};
            S_BUSY:  return {7'b0, ramp_busy};
            default: return {7'b0, wr_err};
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (sig_val(sb[i].sig) !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d actual=0x%02h required=0x%02h",
                             sb[i].name, cyc, sig_val(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(int d, int s, logic [7:0] v, string n);
        exp_t e;
        e.cyc = cyc + d;
        e.sig = s;
        e.val = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(logic [6:0] a, logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
    endtask

    task automatic ramp_setup(logic [7:0] d0, logic [7:0] tgt, logic [7:0] stp,
                              logic [7:0] ctrl);
        wr(7'h04, d0);
        wr(7'h05, tgt);
        wr(7'h06, stp);
        expect_at(1, S_BUSY, 8'h01, "ramp_armed");
        wr(7'h07, ctrl);
        tick(2);
    endtask

    task automatic expect_all_zero(int d, string n);
        for (int s = 0; s < 8; s++) expect_at(d, s, 8'h00, n);
    endtask

    logic [7:0] up_seq[4]   = '{8'h50, 8'h90, 8'hD0, 8'hF0};
    logic [7:0] down_seq[4] = '{8'h04, 8'h03, 8'h03, 8'h02};

    initial begin
        // Reset state
        tick(3);
        expect_all_zero(0, "reset_state");
        tick();
        rst_n = 1'b1;
        tick(2);

        // Immediate mode duty write
        expect_at(1, S_DUTY, 8'h80, "imm_duty");
        expect_at(1, S_PEND, 8'h00, "imm_no_pend");
        expect_at(2, S_PEND, 8'h00, "imm_no_pend2");
        wr(7'h04, 8'h80);
        tick(2);

        // Sync mode: last write wins, commit on period_start
        sync_mode = 1'b1;
        expect_at(1, S_EN0, 8'h00, "sync_hold_a");
        expect_at(1, S_PEND, 8'h01, "sync_pend_set");
        wr(7'h00, 8'hFF);
        expect_at(1, S_EN0, 8'h00, "sync_hold_b");
        expect_at(10, S_EN0, 8'h00, "sync_hold_c");
        expect_at(10, S_PEND, 8'h01, "sync_pend_hold");
        wr(7'h00, 8'h0F);
        tick(19);
        expect_at(0, S_PEND, 8'h01, "sync_pend_pre");
        expect_at(1, S_EN0, 8'h0F, "sync_commit");
        expect_at(1, S_PEND, 8'h00, "sync_pend_clr");
        expect_at(2, S_PEND, 8'h00, "sync_pend_clr2");
        pulse();
        tick(2);

        // Write in the same cycle as period_start joins the commit
        expect_at(1, S_EN2, 8'h00, "same_cyc_hold");
        expect_at(1, S_PEND, 8'h01, "same_cyc_pend");
        wr(7'h02, 8'h11);
        tick(3);
        expect_at(1, S_EN2, 8'h22, "same_cyc_commit");
        expect_at(1, S_PEND, 8'h00, "same_cyc_pend_clr");
        wr_valid = 1'b1;
        wr_addr = 7'h02;
        wr_data = 8'h22;
        period_start = 1'b1;
        tick();
        wr_valid = 1'b0;
        period_start = 1'b0;

        // sync_mode 1 -> 0 while pending flushes shadow
        expect_at(1, S_EN3, 8'h00, "flush_hold");
        expect_at(1, S_PEND, 8'h01, "flush_pend");
        wr(7'h03, 8'h5A);
        tick(2);
        expect_at(1, S_EN3, 8'h5A, "flush_commit");
        expect_at(1, S_PEND, 8'h00, "flush_pend_clr");
        sync_mode = 1'b0;
        tick(2);

        // Upward ramp, div 0
        ramp_setup(8'h10, 8'hF0, 8'h40, 8'h01);
        for (int i = 0; i < 4; i++) begin
            expect_at(1, S_DUTY, up_seq[i], "ramp_up");
            pulse();
            tick(2);
        end
        expect_at(0, S_BUSY, 8'h00, "ramp_up_done");
        expect_at(1, S_DUTY, 8'hF0, "ramp_up_stay");
        pulse();
        tick(2);

        // Downward ramp, step 0 acts as 1, div 1
        ramp_setup(8'h04, 8'h02, 8'h00, 8'h03);
        for (int i = 0; i < 4; i++) begin
            expect_at(1, S_DUTY, down_seq[i], "ramp_down");
            pulse();
            tick(2);
        end
        expect_at(0, S_BUSY, 8'h00, "ramp_down_done");

        // Clamp at 0 and at 255
        ramp_setup(8'h03, 8'h00, 8'h10, 8'h01);
        expect_at(1, S_DUTY, 8'h00, "clamp_low");
        pulse();
        expect_at(1, S_BUSY, 8'h00, "clamp_low_done");
        tick(2);
        ramp_setup(8'hF0, 8'hFF, 8'h40, 8'h01);
        expect_at(1, S_DUTY, 8'hFF, "clamp_high");
        pulse();
        tick(3);

        // Mid-ramp SPI duty write wins and stops the ramp
        ramp_setup(8'h10, 8'hF0, 8'h10, 8'h01);
        expect_at(1, S_DUTY, 8'h20, "mid_ramp_step");
        pulse();
        tick(2);
        expect_at(1, S_DUTY, 8'h33, "spi_wins");
        expect_at(1, S_BUSY, 8'h00, "spi_stops_ramp");
        wr_valid = 1'b1;
        wr_addr = 7'h04;
        wr_data = 8'h33;
        period_start = 1'b1;
        tick();
        wr_valid = 1'b0;
        period_start = 1'b0;
        tick(2);
        for (int i = 0; i < 2; i++) begin
            expect_at(1, S_DUTY, 8'h33, "no_more_steps");
            pulse();
            tick();
        end

        // Unmapped write
        expect_at(1, S_ERR, 8'h01, "wr_err_pulse");
        expect_at(2, S_ERR, 8'h00, "wr_err_clear");
        expect_at(1, S_DUTY, 8'h33, "unmap_duty");
        expect_at(1, S_EN0, 8'h0F, "unmap_en0");
        expect_at(1, S_EN1, 8'h00, "unmap_en1");
        expect_at(1, S_EN2, 8'h22, "unmap_en2");
        expect_at(1, S_EN3, 8'h5A, "unmap_en3");
        expect_at(1, S_BUSY, 8'h00, "unmap_busy");
        wr(7'h12, 8'h99);
        tick(3);

        // Ramp step + pending commit in the same cycle
        sync_mode = 1'b1;
        expect_at(1, S_PEND, 8'h01, "mix_pend");
        wr(7'h01, 8'h44);
        wr(7'h05, 8'hF0);
        wr(7'h06, 8'h10);
        expect_at(1, S_BUSY, 8'h01, "mix_busy");
        wr(7'h07, 8'h01);
        tick(2);
        expect_at(1, S_DUTY, 8'h43, "mix_ramp_duty");
        expect_at(1, S_EN1, 8'h44, "mix_commit_en1");
        expect_at(1, S_PEND, 8'h00, "mix_pend_clr");
        expect_at(1, S_BUSY, 8'h01, "mix_still_busy");
        pulse();

        // Reset while pending with ramp active
        expect_at(1, S_PEND, 8'h01, "pre_rst_pend");
        wr(7'h00, 8'h77);
        tick(2);
        expect_at(0, S_EN0, 8'h0F, "pre_rst_en0");
        expect_at(0, S_BUSY, 8'h01, "pre_rst_busy");
        tick();
        rst_n = 1'b0;
        expect_all_zero(0, "async_rst");
        tick(2);
        rst_n = 1'b1;
        tick(2);
        expect_at(1, S_EN0, 8'h00, "post_rst_no_commit");
        expect_at(1, S_DUTY, 8'h00, "post_rst_duty");
        expect_at(1, S_PEND, 8'h00, "post_rst_pend");
        expect_at(1, S_BUSY, 8'h00, "post_rst_busy");
        pulse();
        tick(3);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending entries required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
